cabac_bae_range_update: RTL and testbench
=========================================

Name: cabac_bae_range_update

Overview:
- Binary arithmetic encoder range stage. Sits directly downstream of the four-entry rLPS lookup (per-pstate rLPS values plus their pre-normalised forms).
- Holds the 9-bit coding range. Processes one bin per cycle: regular, bypass or terminate.
- Emits a registered low-update command (addend, renormalisation shift, mode) to the downstream low/outstanding-bit/bit-packing stage.

Parameters:
- CNT_W, 16, width of accepted-bin counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  slice/flush re-init pulse: range to 510, pipeline cleared.
- bin_valid_i  in  1  bin command valid.
- bin_ready_o  out  1  bin command accepted when valid&&ready.
- bin_i  in  1  bin value.
- mps_i  in  1  MPS of the bin's context (regular bins only).
- bypass_i  in  1  bypass bin.
- term_i  in  1  terminate bin. bypass_i has priority if both are set.
- four_rlps_i  in  32  rLPS for q=0..3 at [31:24],[23:16],[15:8],[7:0]. Combinational from the presented bin's pstate.
- four_rlps_shift_i  in  44  per q (q0 at MSB): {shift[2:0], rlps_shift[7:0]}. rlps_shift = rLPS<<shift with leading 1 dropped.
- out_valid_o  out  1  command valid.
- out_ready_i  in  1  downstream accepts.
- low_add_o  out  10  value added to low.
- shift_o  out  3  renormalisation bit count (0..7).
- mode_o  out  1  0: low=(low+add)<<shift. 1 (bypass): low=(low<<1)+add.
- range_o  out  9  range after this bin (debug/verification).
- bin_cnt_o  out  CNT_W  bins accepted since reset/start.

Behaviour:
Reset values:
- range register 510.
- out_valid_o 0; low_add_o, shift_o, mode_o, bin_cnt_o all 0; range_o 510.

Handshake:
- bin_ready_o = !start_i && (!out_valid_o || out_ready_i).
- An accepted bin updates the range register and output register on the same edge. Latency is 1 cycle.
- Output is held stable while out_valid_o && !out_ready_i.
- If nothing is accepted and out_ready_i is high, out_valid_o clears.

Index selection:
- q = range[7:6], taken from the current range register. Selects rlps and {shift, rlps_shift}.
- rmps = range - rlps (9-bit, no underflow possible).

Regular, bin==mps_i:
- If rmps[8]: range=rmps, shift=0.
- Else: range=rmps<<1, shift=1.
- add=0, mode=0.

Regular, bin!=mps_i:
- add=rmps, range={1'b1, rlps_shift}, shift=shift[q], mode=0.

Bypass:
- add = bin ? range : 0, shift=1, mode=1, range unchanged.

Terminate (r2 = range-2):
- bin=0: add=0. If r2[8]: range=r2, shift=0. Else: range=r2<<1, shift=1.
- bin=1: add=r2, shift=7, range=256 (i.e. 2<<7). mode=0.

Counter:
- bin_cnt_o increments per accepted bin and wraps at 2^CNT_W.

start_i:
- Synchronous, overrides everything: range=510, out_valid_o=0, bin_cnt_o=0.
- No bin is accepted that cycle. A pending unconsumed output is discarded.

Reset mid-operation:
- Asynchronous. All state returns to reset values immediately.

Back-to-back bins:
- The next bin's q uses the range updated by the previous accepted bin. The upstream lookup only depends on pstate, so no bubble is required.

Test Plan:
1. After reset, regular bin, mps=0, bin=0, four_rlps=80B0D0F0, shift field q3={1,E0} -> q=3, range 270, add 0, shift 0, cnt 1.
2. Then, at range 270, bin=0, mps=0, same table (q=0, rlps 128, shift field {1,00}) -> range 284, shift 1. Alternatively with bin=1 -> add 142, range 256, shift 1.
3. From 510, regular LPS, pstate-0 table -> add 270, shift 1, range 480, mode 0.
4. From 510: bypass bin=1 -> add 510, shift 1, mode 1, range 510. Terminate bin=0 -> range 508, shift 0. Terminate bin=1 -> add 508, shift 7, range 256.
5. Hold out_ready_i=0 for 3 cycles with bin_valid_i=1 -> one output held stable, bin_ready_o=0, range frozen. Release -> next bin accepted the same cycle.
6. Assert start_i while out_valid_o=1 -> next cycle out_valid_o=0, range 510, cnt 0. Assert rst mid-stream -> immediate reset values.

Source files
------------

// File: rtl/cabac_bae_range_update_if.sv
// Bin command / low-update command bundle between the rLPS lookup, the
// range stage and the downstream low/bit-packing stage.
interface cabac_bae_range_update_if #(parameter int CNT_W = 16);
  logic             start;
  logic             bin_valid;
  logic             bin_ready;
  logic             bin;
  logic             mps;
  logic             bypass;
  logic             term;
  logic [31:0]      four_rlps;
  logic [43:0]      four_rlps_shift;
  logic             out_valid;
  logic             out_ready;
  logic [9:0]       low_add;
  logic [2:0]       shift;
  logic             mode;
  logic [8:0]       range_val;
  logic [CNT_W-1:0] bin_cnt;

  modport master (
    output start, bin_valid, bin, mps, bypass, term, four_rlps, four_rlps_shift,
    output out_ready,
    input  bin_ready, out_valid, low_add, shift, mode, range_val, bin_cnt
  );

  modport slave (
    input  start, bin_valid, bin, mps, bypass, term, four_rlps, four_rlps_shift,
    input  out_ready,
    output bin_ready, out_valid, low_add, shift, mode, range_val, bin_cnt
  );
endinterface

// File: rtl/cabac_bae_range_update.sv
// Binary arithmetic encoder range stage: one regular/bypass/terminate bin per
// cycle, emits a registered low-update command (addend, shift, mode).
module cabac_bae_range_update #(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  cabac_bae_range_update_if.slave bus
);

  localparam logic [8:0] RANGE_INIT = 9'd510;

  logic [8:0]       range_q;
  logic             out_valid_q;
  logic [9:0]       low_add_q;
  logic [2:0]       shift_q;
  logic             mode_q;
  logic [CNT_W-1:0] bin_cnt_q;

  logic       bin_ready;
  logic       accept;
  logic [1:0] q;
  logic [7:0] rlps;
  logic [7:0] rlps_sh;
  logic [2:0] lps_shift;
  logic [8:0] rmps;
  logic [8:0] r2;

  logic [8:0] nxt_range;
  logic [9:0] nxt_add;
  logic [2:0] nxt_shift;
  logic       nxt_mode;

  assign bin_ready = !bus.start && (!out_valid_q || bus.out_ready);
  assign accept    = bus.bin_valid && bin_ready;

  // Quarter index comes from the live range so back-to-back bins chain without a bubble.
  assign q = range_q[7:6];

  always_comb begin
    rlps      = 8'd0;
    rlps_sh   = 8'd0;
    lps_shift = 3'd0;
    case (q)
      2'd0: begin
        rlps      = bus.four_rlps[31:24];
        lps_shift = bus.four_rlps_shift[43:41];
        rlps_sh   = bus.four_rlps_shift[40:33];
      end
      2'd1: begin
        rlps      = bus.four_rlps[23:16];
        lps_shift = bus.four_rlps_shift[32:30];
        rlps_sh   = bus.four_rlps_shift[29:22];
      end
      2'd2: begin
        rlps      = bus.four_rlps[15:8];
        lps_shift = bus.four_rlps_shift[21:19];
        rlps_sh   = bus.four_rlps_shift[18:11];
      end
      default: begin
        rlps      = bus.four_rlps[7:0];
        lps_shift = bus.four_rlps_shift[10:8];
        rlps_sh   = bus.four_rlps_shift[7:0];
      end
    endcase
  end

  assign rmps = range_q - {1'b0, rlps};
  assign r2   = range_q - 9'd2;

  always_comb begin
    nxt_range = range_q;
    nxt_add   = 10'd0;
    nxt_shift = 3'd0;
    nxt_mode  = 1'b0;
    if (bus.bypass) begin
      nxt_add   = bus.bin ? {1'b0, range_q} : 10'd0;
      nxt_shift = 3'd1;
      nxt_mode  = 1'b1;
    end else if (bus.term) begin
      if (bus.bin) begin
        // Terminating bin flushes: range becomes 2 renormalised by 7.
        nxt_add   = {1'b0, r2};
        nxt_shift = 3'd7;
        nxt_range = 9'd256;
      end else if (r2[8]) begin
        nxt_range = r2;
      end else begin
        nxt_range = {r2[7:0], 1'b0};
        nxt_shift = 3'd1;
      end
    end else if (bus.bin == bus.mps) begin
      if (rmps[8]) begin
        nxt_range = rmps;
      end else begin
        nxt_range = {rmps[7:0], 1'b0};
        nxt_shift = 3'd1;
      end
    end else begin
      nxt_add   = {1'b0, rmps};
      nxt_range = {1'b1, rlps_sh};
      nxt_shift = lps_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_q     <= RANGE_INIT;
      out_valid_q <= 1'b0;
      low_add_q   <= 10'd0;
      shift_q     <= 3'd0;
      mode_q      <= 1'b0;
      bin_cnt_q   <= '0;
    end else if (bus.start) begin
      range_q     <= RANGE_INIT;
      out_valid_q <= 1'b0;
      low_add_q   <= 10'd0;
      shift_q     <= 3'd0;
      mode_q      <= 1'b0;
      bin_cnt_q   <= '0;
    end else if (accept) begin
      range_q     <= nxt_range;
      out_valid_q <= 1'b1;
      low_add_q   <= nxt_add;
      shift_q     <= nxt_shift;
      mode_q      <= nxt_mode;
      bin_cnt_q   <= bin_cnt_q + 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.bin_ready = bin_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.low_add   = low_add_q;
  assign bus.shift     = shift_q;
  assign bus.mode      = mode_q;
  assign bus.range_val = range_q;
  assign bus.bin_cnt   = bin_cnt_q;

endmodule

// File: tb/tb_cabac_bae_range_update.sv
// Directed bench for the CABAC range stage using the pstate-0 rLPS table.
module tb_cabac_bae_range_update;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  cabac_bae_range_update_if #(.CNT_W(16)) bus ();

  cabac_bae_range_update #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int vld, input int add, input int sh,
                         input int md, input int rng, input int cnt);
    chk_val({tag, ".valid"}, {31'd0, bus.out_valid}, vld[31:0]);
    chk_val({tag, ".add"},   {22'd0, bus.low_add},   add[31:0]);
    chk_val({tag, ".shift"}, {29'd0, bus.shift},     sh[31:0]);
    chk_val({tag, ".mode"},  {31'd0, bus.mode},      md[31:0]);
    chk_val({tag, ".range"}, {23'd0, bus.range_val}, rng[31:0]);
    chk_val({tag, ".cnt"},   {16'd0, bus.bin_cnt},   cnt[31:0]);
  endtask

  task automatic send_bin(input logic b, input logic m, input logic byp, input logic trm);
    bus.bin       = b;
    bus.mps       = m;
    bus.bypass    = byp;
    bus.term      = trm;
    bus.bin_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.bin_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    #1;
    chk_val("start.ready", {31'd0, bus.bin_ready}, 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst                 = 1'b1;
    bus.start           = 1'b0;
    bus.bin_valid       = 1'b0;
    bus.bin             = 1'b0;
    bus.mps             = 1'b0;
    bus.bypass          = 1'b0;
    bus.term            = 1'b0;
    bus.out_ready       = 1'b1;
    bus.four_rlps       = 32'h80B0D0F0;
    bus.four_rlps_shift = {3'd1, 8'h00, 3'd1, 8'h60, 3'd1, 8'hA0, 3'd1, 8'hE0};

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 510, 0);
    rst = 1'b0;
    #1;
    chk_val("reset.ready", {31'd0, bus.bin_ready}, 32'd1);

    // q=3 MPS from 510, then back-to-back q=0 MPS from 270
    send_bin(1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("mps_q3", 1, 0, 0, 0, 270, 1);
    send_bin(1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("mps_q0", 1, 0, 1, 0, 284, 2);

    pulse_start();
    chk_out("start1", 0, 0, 0, 0, 510, 0);

    // LPS at range 270, q=0
    send_bin(1'b0, 1'b0, 1'b0, 1'b0);
    send_bin(1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("lps_q0", 1, 142, 1, 0, 256, 2);

    pulse_start();
    send_bin(1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("lps_q3", 1, 270, 1, 0, 480, 1);

    pulse_start();
    send_bin(1'b1, 1'b0, 1'b1, 1'b0);
    chk_out("byp1", 1, 510, 1, 1, 510, 1);
    send_bin(1'b0, 1'b0, 1'b1, 1'b1);
    chk_out("byp_over_term", 1, 0, 1, 1, 510, 2);
    send_bin(1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("term0", 1, 0, 0, 0, 508, 3);

    pulse_start();
    send_bin(1'b1, 1'b0, 1'b0, 1'b1);
    chk_out("term1", 1, 508, 7, 0, 256, 1);
    send_bin(1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("term0_renorm", 1, 0, 1, 0, 508, 2);

    // Backpressure: LPS result held while the next bin waits
    pulse_start();
    bus.out_ready = 1'b0;
    send_bin(1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("bp_first", 1, 270, 1, 0, 480, 1);
    bus.bin       = 1'b0;
    bus.mps       = 1'b0;
    bus.bin_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_val("bp_hold.ready", {31'd0, bus.bin_ready}, 32'd0);
      chk_out("bp_hold", 1, 270, 1, 0, 480, 1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk_val("bp_release.ready", {31'd0, bus.bin_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.bin_valid = 1'b0;
    chk_out("bp_release", 1, 0, 1, 0, 480, 2);
    @(posedge clk);
    #1;
    chk_val("drain.valid", {31'd0, bus.out_valid}, 32'd0);

    // start discards a pending output
    bus.out_ready = 1'b0;
    send_bin(1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("pend", 1, 0, 1, 0, 480, 3);
    pulse_start();
    chk_out("start_discard", 0, 0, 0, 0, 510, 0);
    bus.out_ready = 1'b1;

    // Asynchronous reset between edges
    send_bin(1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("pre_rst", 1, 270, 1, 0, 480, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 510, 0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_bin(1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("post_rst", 1, 0, 0, 0, 270, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
